// File: rtl/cmd_encoder.sv
// Button-to-command producer: synchronise, debounce, press-edge, mode gating, priority encode, show-ahead FIFO.
// Optional build macro CMD_REPEAT_EN adds auto-repeat for held movement buttons.
module cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    btn_raw,
    input  logic                          on_enemy,
    input  logic                          hacks_en,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [15:0]                   cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (1 << PW) != FIFO_DEPTH || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("cmd_encoder: illegal parameter value");
    end

    logic [6:0] btn_event;

    for (genvar gi = 0; gi < 7; gi++) begin : g_btn
        logic          sync1_q, sync2_q;
        logic          deb_q, deb_d, deb_prev_q;
        logic [CW-1:0] cnt_q, cnt_d;

        // Counter only runs while the synced value disagrees with the debounced level.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= btn_raw[gi];
                sync2_q    <= sync1_q;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                cnt_q      <= cnt_d;
            end
        end

`ifdef CMD_REPEAT_EN
        if (gi < 4) begin : g_rep
            localparam int RW = $clog2(REPEAT_CYCLES + 1);
            logic [RW-1:0] rep_q, rep_d;
            logic          rep_hit;

            // Counts cycles of a sustained hold; the initial press cycle restarts it.
            assign rep_hit = deb_q & deb_prev_q & (rep_q == RW'(REPEAT_CYCLES - 1));

            always_comb begin
                rep_d = '0;
                if (deb_q && deb_prev_q && !rep_hit) begin
                    rep_d = rep_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rep_q <= '0;
                end else begin
                    rep_q <= rep_d;
                end
            end

            assign btn_event[gi] = (deb_q & ~deb_prev_q) | rep_hit;
        end else begin : g_norep
            assign btn_event[gi] = deb_q & ~deb_prev_q;
        end
`else
        assign btn_event[gi] = deb_q & ~deb_prev_q;
`endif
    end

    logic [6:0]    pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic          sel_found, sel_allowed, push, pop, full;
    logic [2:0]    sel_idx;
    logic [15:0]   sel_code;

    // Lowest-index pending button wins; gating decides whether it is pushed or discarded.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(k);
            end
        end
        if (sel_idx < 3'd4) begin
            sel_allowed = !on_enemy;
        end else if (sel_idx < 3'd6) begin
            sel_allowed = on_enemy;
        end else begin
            sel_allowed = hacks_en;
        end
        sel_code = (sel_idx == 3'd6) ? 16'h0010 : {13'd0, sel_idx + 3'd1};
    end

    assign cmd_valid  = (count_q != '0);
    assign cmd_data   = cmd_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign full       = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop        = cmd_valid & cmd_ready;
    assign push       = sel_found & sel_allowed & (!full | pop);

    always_comb begin
        pending_d = pending_q;
        if (sel_found && (!sel_allowed || push)) begin
            pending_d[sel_idx] = 1'b0;
        end
        // A new press on a still-pending button is lost rather than merged.
        pending_d = pending_d | (btn_event & ~pending_q);

        overflow_d = overflow_q;
        if (|(btn_event & pending_q)) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_code;
        end
    end
endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: per-cycle reference model plus directed scenarios.
// Define CMD_REPEAT_EN for both bench and design to exercise auto-repeat.
module tb_cmd_encoder;
    localparam int D     = 16;
    localparam int DEPTH = 8;
    localparam int REP   = 64;

    typedef logic [15:0] wq_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  btn_raw = '0;
    logic        on_enemy = 1'b0, hacks_en = 1'b0, cmd_ready = 1'b0, overflow_clr = 1'b0;
    logic        cmd_valid, overflow;
    logic [15:0] cmd_data;
    logic [3:0]  fifo_level;

    cmd_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .on_enemy(on_enemy), .hacks_en(hacks_en),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: raw delay line, stability counting, pending flags and a word queue.
    bit          m_raw1[7], m_raw2[7], m_lvl[7], m_lvl_old[7], m_pend[7];
    int          m_stable[7], m_hold[7];
    bit          m_ovf;
    logic [15:0] m_fifo[$];

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_raw1[i] = 0; m_raw2[i] = 0; m_lvl[i] = 0; m_lvl_old[i] = 0;
            m_pend[i] = 0; m_stable[i] = 0; m_hold[i] = 0;
        end
        m_ovf = 0;
        m_fifo.delete();
    endtask

    task automatic model_step();
        bit pop, push, ok, lost;
        bit ev[7], old_pend[7];
        int k;
        logic [15:0] code;
        pop = (m_fifo.size() != 0) && cmd_ready;
        push = 0; lost = 0; k = -1; code = 16'h0;
        for (int i = 0; i < 7; i++) begin
            old_pend[i] = m_pend[i];
            ev[i] = m_lvl[i] && !m_lvl_old[i];
`ifdef CMD_REPEAT_EN
            if (i < 4 && m_lvl[i] && m_lvl_old[i]) begin
                m_hold[i]++;
                if (m_hold[i] == REP) begin
                    ev[i] = 1;
                    m_hold[i] = 0;
                end
            end else begin
                m_hold[i] = 0;
            end
`endif
            if (m_pend[i] && k < 0) k = i;
        end
        if (k >= 0) begin
            ok = (k < 4) ? !on_enemy : (k < 6) ? on_enemy : hacks_en;
            code = (k == 6) ? 16'h0010 : 16'(k + 1);
            if (!ok) begin
                m_pend[k] = 0;
            end else if (m_fifo.size() < DEPTH || pop) begin
                push = 1;
                m_pend[k] = 0;
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (ev[i] && old_pend[i]) lost = 1;
            else if (ev[i]) m_pend[i] = 1;
        end
        if (lost) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(code);
        for (int i = 0; i < 7; i++) begin
            m_lvl_old[i] = m_lvl[i];
            if (m_raw2[i] == m_lvl[i]) begin
                m_stable[i] = 0;
            end else if (m_stable[i] + 1 == D) begin
                m_lvl[i] = m_raw2[i];
                m_stable[i] = 0;
            end else begin
                m_stable[i]++;
            end
            m_raw2[i] = m_raw1[i];
            m_raw1[i] = btn_raw[i];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model, and capture of every accepted word.
    logic [15:0] got[$];
    int          got_t[$];
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(cmd_valid), 32'(m_fifo.size() != 0));
            check("data", 32'(cmd_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
            check("level", 32'(fifo_level), 32'(m_fifo.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
        if (rst_n && cmd_valid && cmd_ready) begin
            got.push_back(cmd_data);
            got_t.push_back(cyc);
            $display("[TB] cycle %0d word %04h", cyc, cmd_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold, input int gap);
        btn_raw[k] = 1'b1;
        tick(hold);
        btn_raw[k] = 1'b0;
        tick(gap);
    endtask

    task automatic check_words(input string name, input wq_t e);
        check({name, "_count"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), 32'(got[i]), 32'(e[i]));
        end
        got.delete();
        got_t.delete();
    endtask

    initial begin
        tick(4);
        rst_n = 1'b1;
        tick(2);
        chk_en = 1;
        check("reset_valid", 32'(cmd_valid), 32'h0);
        check("reset_data", 32'(cmd_data), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);

        // T1: latency and a single show-ahead word
        cmd_ready = 1'b1;
        btn_raw[0] = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick(1);
            if (c == 19) check("t1_valid_c19", 32'(cmd_valid), 32'h0);
            if (c == 20) begin
                check("t1_valid_c20", 32'(cmd_valid), 32'h1);
                check("t1_data_c20", 32'(cmd_data), 32'h0001);
            end
            if (c == 21) check("t1_valid_c21", 32'(cmd_valid), 32'h0);
        end
        tick(19);
        btn_raw[0] = 1'b0;
        tick(30);
        check_words("t1", '{16'h0001});

        // T2: bouncing contact yields one command
        btn_raw[2] = 1; tick(2); btn_raw[2] = 0; tick(2);
        btn_raw[2] = 1; tick(1); btn_raw[2] = 0; tick(3);
        btn_raw[2] = 1; tick(1); btn_raw[2] = 0; tick(1);
        press(2, 30, 30);
        check_words("t2", '{16'h0003});

        // T3: movement gated while on an enemy, attack allowed
        on_enemy = 1'b1;
        press(0, 25, 25);
        press(4, 25, 25);
        check_words("t3", '{16'h0005});
        check("t3_ovf", 32'(overflow), 32'h0);
        on_enemy = 1'b0;

        // T4: back-pressure, 9th press waits, repeated press overflows, then drain
        cmd_ready = 1'b0;
        hacks_en = 1'b1;
        press(0, 22, 22); press(1, 22, 22); press(2, 22, 22); press(3, 22, 22);
        press(6, 22, 22); press(0, 22, 22); press(1, 22, 22); press(2, 22, 22);
        press(3, 22, 22);
        check("t4_level_full", 32'(fifo_level), 32'h8);
        check("t4_no_ovf", 32'(overflow), 32'h0);
        press(3, 22, 22);
        check("t4_ovf_set", 32'(overflow), 32'h1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'h0);
        cmd_ready = 1'b1;
        tick(20);
        check("t4_level_empty", 32'(fifo_level), 32'h0);
        check_words("t4", '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0010,
                            16'h0001, 16'h0002, 16'h0003, 16'h0004});

        // T5: simultaneous right and down give consecutive words
        btn_raw = 7'b0001001;
        tick(25);
        btn_raw = '0;
        tick(30);
        if (got_t.size() >= 2) check("t5_gap", 32'(got_t[1] - got_t[0]), 32'h1);
        check_words("t5", '{16'h0001, 16'h0004});

        // T6: shroud needs hacks_en
        hacks_en = 1'b0;
        press(6, 25, 25);
        hacks_en = 1'b1;
        press(6, 25, 25);
        check_words("t6", '{16'h0010});

        // T7: reset mid-operation discards queued words
        cmd_ready = 1'b0;
        press(0, 22, 22);
        press(1, 22, 5);
        check("t7_level_pre", 32'(fifo_level), 32'h2);
        rst_n = 1'b0;
        tick(3);
        check("t7_level_rst", 32'(fifo_level), 32'h0);
        check("t7_valid_rst", 32'(cmd_valid), 32'h0);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick(40);
        check_words("t7", '{});

`ifdef CMD_REPEAT_EN
        // T8: held movement button auto-repeats
        press(0, 180, 30);
        check_words("t8", '{16'h0001, 16'h0001, 16'h0001});
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
